// File: rtl/seg_scan_ctrl_if.sv
// Host-side bus of the display scanner: register-file writes, scan enable and the
// multiplexed decoder/digit-enable outputs.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
);
  logic                  display_on;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_addr;
  logic [3:0]            wr_data;
  logic [3:0]            dec_code;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [IDX_W-1:0]      cur_digit;
  logic                  frame_done;

  modport master (
    output display_on, wr_en, wr_addr, wr_data,
    input  dec_code, digit_en, cur_digit, frame_done
  );

  modport slave (
    input  display_on, wr_en, wr_addr, wr_data,
    output dec_code, digit_en, cur_digit, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Round-robin seven-segment scan controller: per-digit code registers feeding one
// shared decoder, with a dark blanking gap before each digit is lit.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int IDX_W        = $clog2(NUM_DIGITS),
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_ctrl_if.slave  bus
);

  localparam int MAX_CNT = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_q, frame_d;
  logic [3:0]       digit_reg_q [NUM_DIGITS];
  logic             wr_ok;

  // Addresses beyond the last digit are silently dropped.
  assign wr_ok = ({1'b0, bus.wr_addr} < (IDX_W + 1)'(NUM_DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_reg_q[i] <= 4'd0;
      end
    end else if (bus.wr_en && wr_ok) begin
      digit_reg_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    frame_d = 1'b0;
    if (!bus.display_on) begin
      state_d = OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            // Wrapping back to digit 0 marks the end of a frame.
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              frame_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode only flops, except dec_code which follows the register file live.
  always_comb begin
    bus.digit_en   = '0;
    bus.dec_code   = 4'd0;
    bus.cur_digit  = idx_q;
    bus.frame_done = frame_q;
    if (state_q == SHOW) begin
      bus.digit_en = NUM_DIGITS'(1) << idx_q;
    end
    if (state_q != OFF) begin
      bus.dec_code = digit_reg_q[idx_q];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected lit digits/codes are queued as stimulus
// is applied and popped as each digit lights up.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = ND * (P + B);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.NUM_DIGITS(4), .IDX_W(2)) bus ();
  seg_scan_ctrl_if #(.NUM_DIGITS(5), .IDX_W(3)) bus5 ();

  seg_scan_ctrl #(.NUM_DIGITS(4), .IDX_W(2), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seg_scan_ctrl #(.NUM_DIGITS(5), .IDX_W(3), .PRESCALE(P), .BLANK_CYCLES(B)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  typedef struct packed {
    logic [3:0] idx;
    logic [3:0] code;
  } exp_t;

  exp_t       expQ [$];
  int         testsRun = 0;
  int         testsFailed = 0;
  logic [3:0] shadow [ND];
  logic [3:0] codes4 [ND] = '{4'h3, 4'h7, 4'h9, 4'hE};
  logic [3:0] codes5 [5]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h6};

  task automatic test_reset();
    #1;
    testsRun++;
    if (bus.digit_en !== 4'd0) begin
      testsFailed++; $display("[TB] FAIL reset_digit_en: got %b expected 0000", bus.digit_en);
    end
    testsRun++;
    if (bus.dec_code !== 4'd0) begin
      testsFailed++; $display("[TB] FAIL reset_dec_code: got %h expected 0", bus.dec_code);
    end
    testsRun++;
    if (bus.cur_digit !== 2'd0) begin
      testsFailed++; $display("[TB] FAIL reset_cur_digit: got %0d expected 0", bus.cur_digit);
    end
    testsRun++;
    if (bus.frame_done !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_frame_done: got %b expected 0", bus.frame_done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++;
    if (bus.digit_en !== 4'd0 || bus.dec_code !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL off_idle: got en=%b code=%h expected en=0000 code=0", bus.digit_en, bus.dec_code);
    end
  endtask

  task automatic test_scan();
    logic [3:0] prevEn, en;
    int darkRun, litRun, nextFrame, frames;
    exp_t e;
    for (int a = 0; a < ND; a++) begin
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = 2'(a); bus.wr_data = codes4[a];
      shadow[a] = codes4[a];
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.display_on = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < ND; d++) expQ.push_back('{idx: 4'(d), code: codes4[d]});
    prevEn = 4'd0; darkRun = 0; litRun = 0; nextFrame = FRAME + 1; frames = 0;
    for (int cyc = 1; cyc <= 2 * FRAME + 2; cyc++) begin
      @(posedge clk); @(negedge clk);
      en = bus.digit_en;
      if (en != 4'd0 && prevEn == 4'd0) begin
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++; $display("[TB] FAIL scan_extra_digit: got en=%b at cycle %0d expected none", en, cyc);
        end else begin
          e = expQ.pop_front();
          if (en !== (4'(1) << e.idx) || bus.dec_code !== e.code || darkRun != B) begin
            testsFailed++;
            $display("[TB] FAIL scan_digit: got en=%b code=%h gap=%0d expected en=%b code=%h gap=%0d",
                     en, bus.dec_code, darkRun, 4'(1) << e.idx, e.code, B);
          end
        end
        litRun = 0;
      end
      if (en == 4'd0 && prevEn != 4'd0) begin
        testsRun++;
        if (litRun != P) begin
          testsFailed++; $display("[TB] FAIL scan_lit_len: got %0d expected %0d", litRun, P);
        end
      end
      if (en != 4'd0) begin litRun++; darkRun = 0; end
      else darkRun++;
      if (bus.frame_done) begin
        testsRun++;
        if (cyc != nextFrame || en != 4'd0) begin
          testsFailed++;
          $display("[TB] FAIL scan_frame_done: got cycle %0d en=%b expected cycle %0d en=0000", cyc, en, nextFrame);
        end
        nextFrame += FRAME; frames++;
      end
      prevEn = en;
    end
    testsRun++;
    if (frames != 2 || expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scan_totals: got frames=%0d pending=%0d expected frames=2 pending=0", frames, expQ.size());
    end
    expQ.delete();
  endtask

  task automatic test_live_write();
    bit found;
    int litRun, darkRun;
    exp_t e;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.digit_en == 4'b0010) found = 1'b1;
    end
    testsRun++;
    if (!found) begin
      testsFailed++; $display("[TB] FAIL live_wait: got no digit 1 expected digit_en=0010 within 100 cycles"); return;
    end
    litRun = 1;
    testsRun++;
    if (bus.dec_code !== shadow[1]) begin
      testsFailed++; $display("[TB] FAIL live_before: got %h expected %h", bus.dec_code, shadow[1]);
    end
    @(posedge clk); @(negedge clk);
    litRun++;
    bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 4'h5;
    expQ.push_back('{idx: 4'd1, code: 4'h5});
    shadow[1] = 4'h5;
    @(posedge clk); @(negedge clk);
    bus.wr_en = 1'b0;
    litRun++;
    e = expQ.pop_front();
    testsRun++;
    if (bus.dec_code !== e.code || bus.digit_en !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL live_after: got code=%h en=%b expected code=%h en=0010", bus.dec_code, bus.digit_en, e.code);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.digit_en == 4'b0010) litRun++;
      else break;
    end
    testsRun++;
    if (litRun != P) begin
      testsFailed++; $display("[TB] FAIL live_lit_len: got %0d expected %0d", litRun, P);
    end
    darkRun = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.digit_en == 4'd0) darkRun++;
      else break;
    end
    testsRun++;
    if (darkRun != B || bus.digit_en !== 4'b0100 || bus.dec_code !== shadow[2]) begin
      testsFailed++;
      $display("[TB] FAIL live_next: got gap=%0d en=%b code=%h expected gap=%0d en=0100 code=%h",
               darkRun, bus.digit_en, bus.dec_code, B, shadow[2]);
    end
  endtask

  task automatic test_disable();
    bit found;
    int offBad, darkRun;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.digit_en == 4'b1000) found = 1'b1;
    end
    testsRun++;
    if (!found) begin
      testsFailed++; $display("[TB] FAIL disable_wait: got no digit 3 expected digit_en=1000 within 100 cycles"); return;
    end
    @(posedge clk); @(negedge clk);
    bus.display_on = 1'b0;
    @(posedge clk); @(negedge clk);
    testsRun++;
    if (bus.digit_en !== 4'd0 || bus.cur_digit !== 2'd0 || bus.dec_code !== 4'd0 || bus.frame_done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL disable_now: got en=%b cur=%0d code=%h fd=%b expected 0000/0/0/0",
               bus.digit_en, bus.cur_digit, bus.dec_code, bus.frame_done);
    end
    offBad = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (bus.digit_en != 4'd0 || bus.frame_done) offBad++;
    end
    testsRun++;
    if (offBad != 0) begin
      testsFailed++; $display("[TB] FAIL disable_hold: got %0d active cycles expected 0", offBad);
    end
    bus.display_on = 1'b1;
    darkRun = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.digit_en == 4'd0) darkRun++;
      else break;
    end
    testsRun++;
    if (darkRun != B || bus.digit_en !== 4'b0001 || bus.dec_code !== shadow[0] || bus.cur_digit !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL reenable: got gap=%0d en=%b code=%h cur=%0d expected gap=%0d en=0001 code=%h cur=0",
               darkRun, bus.digit_en, bus.dec_code, bus.cur_digit, B, shadow[0]);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    int darkRun;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.digit_en == 4'b0100) found = 1'b1;
    end
    testsRun++;
    if (!found) begin
      testsFailed++; $display("[TB] FAIL areset_wait: got no digit 2 expected digit_en=0100 within 100 cycles"); return;
    end
    #2 rst_n = 1'b0;
    #1;
    testsRun++;
    if ({bus.digit_en, bus.dec_code, bus.cur_digit, bus.frame_done} !== 11'd0) begin
      testsFailed++;
      $display("[TB] FAIL areset_immediate: got en=%b code=%h cur=%0d fd=%b expected all zero",
               bus.digit_en, bus.dec_code, bus.cur_digit, bus.frame_done);
    end
    for (int a = 0; a < ND; a++) shadow[a] = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    darkRun = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.digit_en == 4'd0) darkRun++;
      else break;
    end
    testsRun++;
    if (darkRun != B || bus.digit_en !== 4'b0001 || bus.dec_code !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL areset_restart: got gap=%0d en=%b code=%h expected gap=%0d en=0001 code=0",
               darkRun, bus.digit_en, bus.dec_code, B);
    end
  endtask

  task automatic test_invalid_addr();
    logic [4:0] prevEn, en;
    int frameCyc;
    exp_t e;
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      bus5.wr_en = 1'b1; bus5.wr_addr = 3'(a);
      bus5.wr_data = (a < 5) ? codes5[a] : 4'hF;
    end
    @(negedge clk);
    bus5.wr_en = 1'b0;
    bus5.display_on = 1'b1;
    for (int d = 0; d < 5; d++) expQ.push_back('{idx: 4'(d), code: codes5[d]});
    prevEn = 5'd0; frameCyc = 0;
    for (int cyc = 1; cyc <= 5 * (P + B) + 2; cyc++) begin
      @(posedge clk); @(negedge clk);
      en = bus5.digit_en;
      if (en != 5'd0 && prevEn == 5'd0 && expQ.size() != 0) begin
        e = expQ.pop_front();
        testsRun++;
        if (en !== (5'(1) << e.idx) || bus5.dec_code !== e.code) begin
          testsFailed++;
          $display("[TB] FAIL invalid_addr_digit: got en=%b code=%h expected en=%b code=%h",
                   en, bus5.dec_code, 5'(1) << e.idx, e.code);
        end
      end
      if (bus5.frame_done && frameCyc == 0) frameCyc = cyc;
      prevEn = en;
    end
    testsRun++;
    if (expQ.size() != 0 || frameCyc != 5 * (P + B) + 1) begin
      testsFailed++;
      $display("[TB] FAIL invalid_addr_frame: got pending=%0d frame_cycle=%0d expected pending=0 frame_cycle=%0d",
               expQ.size(), frameCyc, 5 * (P + B) + 1);
    end
    expQ.delete();
    bus5.display_on = 1'b0;
  endtask

  task automatic test_random_invariants();
    logic [3:0] prevEn, en;
    int ohBad, fdBad, gapBad, codeBad, zeroRun, litCycles;
    bit seenLit;
    ohBad = 0; fdBad = 0; gapBad = 0; codeBad = 0; zeroRun = 0; litCycles = 0;
    seenLit = 1'b0;
    prevEn = bus.digit_en;
    for (int n = 0; n < 1000; n++) begin
      bus.wr_en      = ($urandom_range(0, 3) == 0);
      bus.wr_addr    = 2'($urandom_range(0, 3));
      bus.wr_data    = 4'($urandom_range(0, 15));
      bus.display_on = ($urandom_range(0, 99) != 0);
      @(posedge clk);
      if (bus.wr_en) shadow[bus.wr_addr] = bus.wr_data;
      @(negedge clk);
      en = bus.digit_en;
      if (!$onehot0(en) || (en != 4'd0 && en != (4'(1) << bus.cur_digit))) ohBad++;
      if (bus.frame_done && en != 4'd0) fdBad++;
      if (en != 4'd0 && prevEn != 4'd0 && en != prevEn) gapBad++;
      if (en != 4'd0 && prevEn == 4'd0 && seenLit && zeroRun < B) gapBad++;
      if (en != 4'd0 && bus.dec_code !== shadow[bus.cur_digit]) codeBad++;
      if (en != 4'd0) begin seenLit = 1'b1; zeroRun = 0; litCycles++; end
      else zeroRun++;
      prevEn = en;
    end
    bus.wr_en = 1'b0;
    testsRun++;
    if (ohBad != 0) begin testsFailed++; $display("[TB] FAIL inv_onehot: got %0d bad cycles expected 0", ohBad); end
    testsRun++;
    if (fdBad != 0) begin testsFailed++; $display("[TB] FAIL inv_frame_excl: got %0d bad cycles expected 0", fdBad); end
    testsRun++;
    if (gapBad != 0) begin testsFailed++; $display("[TB] FAIL inv_gap: got %0d bad transitions expected 0", gapBad); end
    testsRun++;
    if (codeBad != 0) begin testsFailed++; $display("[TB] FAIL inv_code: got %0d bad cycles expected 0", codeBad); end
    testsRun++;
    if (litCycles < 300) begin
      testsFailed++; $display("[TB] FAIL inv_activity: got %0d lit cycles expected at least 300", litCycles);
    end
  endtask

  initial begin
    bus.display_on = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus5.display_on = 1'b0; bus5.wr_en = 1'b0; bus5.wr_addr = '0; bus5.wr_data = '0;
    for (int a = 0; a < ND; a++) shadow[a] = 4'd0;
    test_reset();
    test_scan();
    test_live_write();
    test_disable();
    test_async_reset();
    test_invalid_addr();
    test_random_invariants();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
